adder_chunked: RTL and testbench
================================

Name: adder_chunked

Overview:
Parametrised multi-cycle add/subtract unit, the sequential successor to the 8-bit combinational adder. It adds WIDTH-bit operands CHUNK bits per clock, rippling the carry through a register between chunks, so wide adders close timing with a narrow carry chain. Valid/ready handshakes on input and output let it sit between pipeline stages of the ALU datapath.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK (elaboration error otherwise)
CHUNK, 8, bits summed per clock cycle; NCH = WIDTH/CHUNK cycles per operation; CHUNK=WIDTH gives a single-cycle adder

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and mode valid
in_ready  output  1  unit idle, accepts operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0: res = a+b+cin; 1: res = a-b (cin ignored)
cin  input  1  carry-in for add mode
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
res  output  WIDTH  sum/difference, modulo 2^WIDTH
cout  output  1  carry out of MSB (sub: 1 = no borrow)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (rst_n low, async): state IDLE; res=0, cout=0, ovf=0, out_valid=0; in_ready=1. Takes effect immediately, including mid-operation; a partial operation is discarded and never presented.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE: on edge with in_valid=1, capture a, b_eff = sub ? ~b : b, carry = sub ? 1 : cin, chunk index = 0, sign bits a[MSB] and b_eff[MSB]; go to RUN. in_valid=0: stay.
- RUN: each cycle compute chunk i = a[i] + b_eff[i] + carry (CHUNK+1 bits); register CHUNK sum bits into res slice i, MSB into carry; increment index. After chunk NCH-1 is registered: cout = final carry, ovf = (a_msb == b_eff_msb) && (res[MSB] != a_msb); go to DONE.
- Latency: out_valid rises exactly NCH clock edges after the accept edge.
- RUN ignores in_valid, a, b, sub, cin entirely (operands are held internally); changes to inputs during RUN do not affect result.
- DONE: res/cout/ovf stable while out_valid=1 and out_ready=0 (backpressure indefinite). On edge with out_ready=1: go to IDLE. No new operation is accepted on the same edge as the output handshake; minimum spacing between accepts is NCH+2 cycles.
- After handshake res/cout/ovf keep the last value until the next operation overwrites them (res slices update progressively during RUN; only valid when out_valid=1).
- Chunk index counter is ceil(log2(NCH)) bits min 1; with NCH=1 RUN lasts one cycle.
- Subtract: a + ~b + 1; cout=1 iff a >= b unsigned. ovf uses b_eff so signed a-b overflow is flagged correctly.
- out_ready high while not in DONE has no effect.

Test Plan:
WIDTH=32, CHUNK=8 (NCH=4) unless noted.
1. a=42, b=1, sub=0, cin=0 -> res=43, cout=0, ovf=0, out_valid exactly 4 edges after accept; then a=10, b=20, cin=1 -> res=31.
2. a=0xFFFFFFFF, b=1, sub=0 -> res=0, cout=1, ovf=0 (carry ripples through all 4 chunks); a=0x7FFFFFFF, b=1 -> res=0x80000000, cout=0, ovf=1.
3. sub=1: a=7, b=5 -> res=2, cout=1, ovf=0; a=5, b=7 -> res=0xFFFFFFFE, cout=0; a=0x80000000, b=1 -> res=0x7FFFFFFF, ovf=1.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> res/cout/ovf unchanged, in_ready=0, in_valid pulses with new operands ignored; out_ready=1 -> IDLE next edge, in_ready=1; result unaffected by operand changes during RUN.
5. Reset: assert rst_n=0 two cycles into RUN (between edges) -> out_valid=0, res=0, in_ready=1 immediately; after release, a=100, b=200 -> res=300 with normal latency.
6. Parameter sweep: WIDTH=8, CHUNK=8 (NCH=1): a=255, b=32 -> res=31, cout=1, latency 1; WIDTH=16, CHUNK=4: a=0x0FFF, b=1 -> res=0x1000, latency 4; random 1000 ops vs reference model with random out_ready.

Source files
------------

// File: rtl/adder_chunked.sv
// adder_chunked: multi-cycle add/subtract, CHUNK bits per clock with a registered ripple carry
module adder_chunked #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);
    localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}});

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("adder_chunked: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [31:0]      sh;
    logic [CHUNK:0]   sum;

    // Next state: capture operands on accept, sum one chunk per RUN cycle, hold result in DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        sh      = 32'(idx_q) * 32'(CHUNK);
        sum     = {1'b0, CHUNK'(a_q >> sh)} + {1'b0, CHUNK'(b_q >> sh)} + {{CHUNK{1'b0}}, carry_q};
        unique case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = sub ? ~b : b;
                carry_d = sub | cin;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                res_d   = (res_q & ~(MASK << sh)) | (WIDTH'(sum[CHUNK-1:0]) << sh);
                carry_d = sum[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    cout_d  = sum[CHUNK];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[CHUNK-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; async reset discards any partial operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign res       = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_adder_chunked.sv
// tb_adder_chunked: directed and randomised checks of adder_chunked at three parameter points
module tb_adder_chunked;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [31:0] a = '0, b = '0, res;
    logic        in_ready, out_valid, cout, ovf;
    logic        iv8 = 1'b0, ir8, ov8, c8, o8;
    logic [7:0]  a8 = '0, b8 = '0, r8;
    logic        iv16 = 1'b0, ir16, ov16, c16, o16;
    logic [15:0] a16 = '0, b16 = '0, r16;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    adder_chunked #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .res(res),
        .cout(cout), .ovf(ovf));

    adder_chunked #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .sub(1'b0), .cin(1'b0), .out_valid(ov8), .out_ready(1'b1), .res(r8),
        .cout(c8), .ovf(o8));

    adder_chunked #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .sub(1'b0), .cin(1'b0), .out_valid(ov16), .out_ready(1'b1), .res(r16),
        .cout(c16), .ovf(o16));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic ts, input logic tc, input logic [31:0] er,
                          input logic ec, input logic eo, input int hold);
        int lat;
        check({tag, ":in_ready"}, 64'(in_ready), 64'd1);
        a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1;
        tick;
        in_valid = 1'b0; a = $urandom; b = $urandom; sub = ~ts; cin = ~tc;
        lat = 0;
        while (!out_valid && lat < 20) begin
            out_ready = 1'($urandom);
            tick;
            lat++;
        end
        out_ready = 1'b0;
        check({tag, ":latency"}, 64'(lat), 64'd4);
        check({tag, ":res"}, 64'(res), 64'(er));
        check({tag, ":cout"}, 64'(cout), 64'(ec));
        check({tag, ":ovf"}, 64'(ovf), 64'(eo));
        repeat (hold) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom);
            tick;
            check({tag, ":hold_res"}, 64'({cout, ovf, res}), 64'({ec, eo, er}));
            check({tag, ":hold_valid"}, 64'({out_valid, in_ready}), 64'b10);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({tag, ":post_hs"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] ra, rb, er;
        logic        rs, rc, ec, eo;
        longint      sv;
        repeat (2) @(posedge clk);
        #1;
        check("rst:state", 64'({in_ready, out_valid, cout, ovf}), 64'b1000);
        check("rst:res", 64'(res), 64'd0);
        rst_n = 1'b1;
        tick;

        iv8 = 1'b1; a8 = 8'd255; b8 = 8'd32;
        tick;
        iv8 = 1'b0; lat = 0;
        while (!ov8 && lat < 20) begin tick; lat++; end
        check("w8:latency", 64'(lat), 64'd1);
        check("w8:res", 64'({c8, o8, r8}), 64'({1'b1, 1'b0, 8'd31}));

        iv16 = 1'b1; a16 = 16'h0FFF; b16 = 16'h0001;
        tick;
        iv16 = 1'b0; lat = 0;
        while (!ov16 && lat < 20) begin tick; lat++; end
        check("w16:latency", 64'(lat), 64'd4);
        check("w16:res", 64'({c16, o16, r16}), 64'({1'b0, 1'b0, 16'h1000}));

        run_op("add42",   32'd42,         32'd1,  1'b0, 1'b0, 32'd43,         1'b0, 1'b0, 0);
        run_op("addcin",  32'd10,         32'd20, 1'b0, 1'b1, 32'd31,         1'b0, 1'b0, 0);
        run_op("ripple",  32'hFFFFFFFF,   32'd1,  1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 0);
        run_op("posovf",  32'h7FFFFFFF,   32'd1,  1'b0, 1'b0, 32'h80000000,   1'b0, 1'b1, 0);
        run_op("sub75",   32'd7,          32'd5,  1'b1, 1'b0, 32'd2,          1'b1, 1'b0, 0);
        run_op("subcin",  32'd7,          32'd5,  1'b1, 1'b1, 32'd2,          1'b1, 1'b0, 0);
        run_op("sub57",   32'd5,          32'd7,  1'b1, 1'b0, 32'hFFFFFFFE,   1'b0, 1'b0, 0);
        run_op("subovf",  32'h80000000,   32'd1,  1'b1, 1'b0, 32'h7FFFFFFF,   1'b1, 1'b1, 0);
        run_op("bp",      32'h12345678,   32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 5);
        run_op("negovf",  32'h80000000,   32'h80000000, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 0);

        a = 32'd5; b = 32'd6; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        #2 rst_n = 1'b0;
        #1;
        check("midrst:state", 64'({in_ready, out_valid, cout, ovf}), 64'b1000);
        check("midrst:res", 64'(res), 64'd0);
        tick;
        check("midrst:held", 64'({in_ready, out_valid}), 64'b10);
        rst_n = 1'b1;
        tick;
        run_op("after_rst", 32'd100, 32'd200, 1'b0, 1'b0, 32'd300, 1'b0, 1'b0, 0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
            if (rs) begin
                er = ra - rb;
                ec = (ra >= rb);
                sv = longint'(signed'(ra)) - longint'(signed'(rb));
            end else begin
                {ec, er} = 33'(ra) + 33'(rb) + 33'(rc);
                sv = longint'(signed'(ra)) + longint'(signed'(rb)) + longint'(rc);
            end
            eo = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
            run_op("rand", ra, rb, rs, rc, er, ec, eo, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
